// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: registered N-digit seven-segment driver with
// per-digit blink, hex/decimal decode, zero blanking and lamp test.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    dec_mode,
    input  logic                    blank_lz,
    input  logic                    lamp_test,
    output logic [7*NUM_DIGITS-1:0] leds
);

    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] TERM = CW'(BLINK_DIV - 1);
    localparam logic [7*NUM_DIGITS-1:0] UNLIT = {(7*NUM_DIGITS){ACTIVE_LOW}};

    typedef enum logic {VISIBLE = 1'b0, HIDDEN = 1'b1} phase_t;

    phase_t                  phase, phase_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   mask_q;
    logic                    loaded;
    logic                    hidden;
    logic [7*NUM_DIGITS-1:0] leds_nxt;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        unique case (n)
            4'h0: g = 7'b0111111;
            4'h1: g = 7'b0000110;
            4'h2: g = 7'b1011011;
            4'h3: g = 7'b1001111;
            4'h4: g = 7'b1100110;
            4'h5: g = 7'b1101101;
            4'h6: g = 7'b1111101;
            4'h7: g = 7'b0000111;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1101111;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b1111100;
            4'hC: g = 7'b0111001;
            4'hD: g = 7'b1011110;
            4'hE: g = 7'b1111001;
            4'hF: g = 7'b1110001;
        endcase
        return g;
    endfunction

    // Blink FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= VISIBLE;
            cnt   <= '0;
        end else begin
            phase <= phase_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Load wins over the terminal-count wrap
    always_comb begin
        phase_nxt = phase;
        cnt_nxt   = cnt + 1'b1;
        if (load) begin
            phase_nxt = VISIBLE;
            cnt_nxt   = '0;
        end else if (cnt == TERM) begin
            phase_nxt = (phase == VISIBLE) ? HIDDEN : VISIBLE;
            cnt_nxt   = '0;
        end
    end

    always_comb begin
        hidden = (phase == HIDDEN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            mask_q  <= '0;
            loaded  <= 1'b0;
        end else if (load) begin
            value_q <= value;
            mask_q  <= blink_mask;
            loaded  <= 1'b1;
        end
    end

    // Scan from the top digit so zero_run tracks "this and all above are 0"
    always_comb begin
        logic [6:0] seg;
        logic [3:0] nib;
        logic       zero_run;
        leds_nxt = UNLIT;
        seg      = '0;
        nib      = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib      = value_q[4*i +: 4];
            zero_run = zero_run & (nib == 4'h0);
            if (lamp_test)
                seg = 7'h7F;
            else if (hidden && mask_q[i])
                seg = 7'h00;
            else if (blank_lz && zero_run && (i != 0))
                seg = 7'h00;
            else if (dec_mode && (nib > 4'h9))
                seg = 7'b1000000;
            else
                seg = glyph(nib);
            leds_nxt[7*i +: 7] = seg ^ {7{ACTIVE_LOW}};
        end
        if (!loaded)
            leds_nxt = UNLIT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            leds <= UNLIT;
        else
            leds <= leds_nxt;
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: directed checks of decode, blanking,
// lamp test, blink timing and load/reset interactions.
module tb_hex_display_ctrl;

    localparam int ND = 6;

    localparam logic [6:0] G0   = 7'h40;
    localparam logic [6:0] G1   = 7'h79;
    localparam logic [6:0] G2   = 7'h24;
    localparam logic [6:0] GA   = 7'h08;
    localparam logic [6:0] GC   = 7'h46;
    localparam logic [6:0] GF   = 7'h0E;
    localparam logic [6:0] DASH = 7'h3F;
    localparam logic [6:0] OFF  = 7'h7F;
    localparam logic [41:0] ALL_OFF = 42'h3FF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          load;
    logic [23:0]   value;
    logic [ND-1:0] blink_mask;
    logic          dec_mode;
    logic          blank_lz;
    logic          lamp_test;
    logic [41:0]   leds;
    logic [41:0]   exp_v;

    int n_checks = 0;
    int n_fail   = 0;

    hex_display_ctrl #(
        .NUM_DIGITS(ND),
        .BLINK_DIV (4),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .value     (value),
        .blink_mask(blink_mask),
        .dec_mode  (dec_mode),
        .blank_lz  (blank_lz),
        .lamp_test (lamp_test),
        .leds      (leds)
    );

    always #5 clk = ~clk;

    // Returns at the falling edge after the edge that first shows the load
    task automatic do_load(input logic [23:0] v, input logic [ND-1:0] m);
        value      = v;
        blink_mask = m;
        load       = 1'b1;
        @(negedge clk);
        load       = 1'b0;
        value      = 24'hFFFFFF;
        blink_mask = '1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (leds !== ALL_OFF) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected %h", leds, ALL_OFF);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (leds !== ALL_OFF) begin
            n_fail++;
            $display("FAIL pre_load: got %h expected %h", leds, ALL_OFF);
        end
    endtask

    task automatic test_decode();
        do_load(24'h0012AF, 6'h00);
        exp_v = {G0, G0, G1, G2, GA, GF};
        n_checks++;
        if (leds !== exp_v) begin
            n_fail++;
            $display("FAIL hex_decode: got %h expected %h", leds, exp_v);
        end
    endtask

    task automatic test_blank_lz();
        blank_lz = 1'b1;
        @(negedge clk);
        exp_v = {OFF, OFF, G1, G2, GA, GF};
        n_checks++;
        if (leds !== exp_v) begin
            n_fail++;
            $display("FAIL lz_partial: got %h expected %h", leds, exp_v);
        end
        do_load(24'h000000, 6'h00);
        exp_v = {OFF, OFF, OFF, OFF, OFF, G0};
        n_checks++;
        if (leds !== exp_v) begin
            n_fail++;
            $display("FAIL lz_zero: got %h expected %h", leds, exp_v);
        end
        do_load(24'h010000, 6'h00);
        exp_v = {OFF, G1, G0, G0, G0, G0};
        n_checks++;
        if (leds !== exp_v) begin
            n_fail++;
            $display("FAIL lz_inner: got %h expected %h", leds, exp_v);
        end
        blank_lz = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dec_lamp();
        dec_mode = 1'b1;
        do_load(24'h00000C, 6'h00);
        exp_v = {G0, G0, G0, G0, G0, DASH};
        n_checks++;
        if (leds !== exp_v) begin
            n_fail++;
            $display("FAIL dec_dash: got %h expected %h", leds, exp_v);
        end
        dec_mode = 1'b0;
        @(negedge clk);
        exp_v = {G0, G0, G0, G0, G0, GC};
        n_checks++;
        if (leds !== exp_v) begin
            n_fail++;
            $display("FAIL hex_c: got %h expected %h", leds, exp_v);
        end
        // Load at edge k; phase turns HIDDEN at k+4, visible on leds at k+5
        do_load(24'h00000C, 6'h3F);
        repeat (3) @(negedge clk);
        n_checks++;
        if (leds !== exp_v) begin
            n_fail++;
            $display("FAIL blink_last_vis: got %h expected %h", leds, exp_v);
        end
        lamp_test = 1'b1;
        @(negedge clk);
        n_checks++;
        if (leds !== 42'h0) begin
            n_fail++;
            $display("FAIL lamp_hidden: got %h expected %h", leds, 42'h0);
        end
        lamp_test = 1'b0;
        @(negedge clk);
        n_checks++;
        if (leds !== ALL_OFF) begin
            n_fail++;
            $display("FAIL all_hidden: got %h expected %h", leds, ALL_OFF);
        end
    endtask

    task automatic test_blink();
        logic [41:0] vis, hid;
        vis = {G0, G0, G1, G2, GA, GF};
        hid = {G0, G0, G1, G2, GA, OFF};
        do_load(24'h0012AF, 6'h01);
        for (int j = 1; j <= 14; j++) begin
            exp_v = (((j - 1) / 4) % 2 == 0) ? vis : hid;
            n_checks++;
            if (leds !== exp_v) begin
                n_fail++;
                $display("FAIL blink_cycle%0d: got %h expected %h", j, leds, exp_v);
            end
            if (j < 14) @(negedge clk);
        end
        // Reload while hidden: count restarts from the load edge
        do_load(24'h0012AF, 6'h01);
        for (int j = 1; j <= 6; j++) begin
            exp_v = (j <= 4) ? vis : hid;
            n_checks++;
            if (leds !== exp_v) begin
                n_fail++;
                $display("FAIL reload_cycle%0d: got %h expected %h", j, leds, exp_v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [41:0] vis, hid;
        vis = {G0, G0, G1, G2, GA, GF};
        hid = {G0, G0, G1, G2, GA, OFF};
        do_load(24'h0012AF, 6'h01);
        repeat (2) @(negedge clk);
        // Counter sits at terminal count; this load lands on the wrap edge
        value      = 24'h0012AF;
        blink_mask = 6'h01;
        load       = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int j = 0; j <= 5; j++) begin
            exp_v = (j <= 4) ? vis : hid;
            n_checks++;
            if (leds !== exp_v) begin
                n_fail++;
                $display("FAIL term_load%0d: got %h expected %h", j, leds, exp_v);
            end
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (leds !== ALL_OFF) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", leds, ALL_OFF);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (leds !== ALL_OFF) begin
            n_fail++;
            $display("FAIL reset_no_load: got %h expected %h", leds, ALL_OFF);
        end
        do_load(24'h0012AF, 6'h00);
        n_checks++;
        if (leds !== vis) begin
            n_fail++;
            $display("FAIL reload_after_reset: got %h expected %h", leds, vis);
        end
    endtask

    initial begin
        reset      = 1'b1;
        load       = 1'b0;
        value      = '0;
        blink_mask = '0;
        dec_mode   = 1'b0;
        blank_lz   = 1'b0;
        lamp_test  = 1'b0;
        @(negedge clk);
        test_reset();
        test_decode();
        test_blank_lz();
        test_dec_lamp();
        test_blink();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
